blackparrot_fpga_host_cmd_arbiter: RTL

Shares the single host-to-BlackParrot FIFO command port, the one that feeds the FIFO-to-AXI converter, between several host-side command sources, such as the NBF loader and a debug/MMIO poke engine. The block grants sources round-robin, tracks outstanding AXI writes with a credit counter, stalls writes when credits run out, and executes per-source fences that drain all outstanding writes before the fence completes. It sits between the command sources and the FIFO-to-AXI converter, in the `m_axi_aclk` domain.

---
 rtl/blackparrot_fpga_host_cmd_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/blackparrot_fpga_host_cmd_arbiter.sv
// Round-robin arbiter for the shared host-to-BlackParrot command port.
// It tracks outstanding AXI writes with a credit counter and stalls writes
// when no credits are left. A fence is held until every outstanding write
// has completed.
module blackparrot_fpga_host_cmd_arbiter #(
  parameter int num_req_p     = 2,
  parameter int addr_width_p  = 64,
  parameter int data_width_p  = 64,
  parameter int max_credits_p = 16,
  localparam int gnt_w_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cnt_w_lp     = $clog2(max_credits_p + 1)
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p-1:0]              req_fence_i,
  input  logic [num_req_p-1:0]              req_w_i,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  input  logic [num_req_p*3-1:0]            req_size_i,
  output logic [num_req_p-1:0]              req_ready_and_o,
  output logic                              cmd_v_o,
  output logic                              cmd_w_o,
  output logic [addr_width_p-1:0]           cmd_addr_o,
  output logic [data_width_p-1:0]           cmd_data_o,
  output logic [2:0]                        cmd_size_o,
  input  logic                              cmd_ready_and_i,
  input  logic                              wr_done_i,
  output logic [gnt_w_lp-1:0]               grant_o,
  output logic                              credits_empty_o,
  output logic                              error_o
);

  typedef enum logic [1:0] {e_idle, e_send, e_fence} state_e;

  state_e                state_q, state_d;
  logic [gnt_w_lp-1:0]   gnt_q, gnt_d;
  logic [gnt_w_lp-1:0]   rr_q, rr_d;
  logic [gnt_w_lp-1:0]   rr_next;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic                  error_q, error_d;

  logic                  pick_found;
  logic [gnt_w_lp-1:0]   pick_idx;
  logic                  credits_full;
  logic                  send_v;
  logic                  cmd_hs;
  logic                  wr_hs;
  logic                  fence_done;

  assign credits_full    = (count_q == cnt_w_lp'(max_credits_p));
  assign credits_empty_o = (count_q == '0);
  assign error_o         = error_q;
  assign grant_o         = gnt_q;

  // The granted requester's fields go straight to the converter.
  assign cmd_w_o    = req_w_i[gnt_q];
  assign cmd_addr_o = req_addr_i[int'(gnt_q)*addr_width_p +: addr_width_p];
  assign cmd_data_o = req_data_i[int'(gnt_q)*data_width_p +: data_width_p];
  assign cmd_size_o = req_size_i[int'(gnt_q)*3 +: 3];

  // A write at full credits waits. A read goes ahead at any credit level.
  assign send_v     = (state_q == e_send) & req_v_i[gnt_q]
                    & ~(req_w_i[gnt_q] & credits_full);
  assign cmd_v_o    = send_v;
  assign cmd_hs     = send_v & cmd_ready_and_i;
  assign wr_hs      = cmd_hs & req_w_i[gnt_q];
  assign fence_done = (state_q == e_fence) & req_v_i[gnt_q] & credits_empty_o;

  assign rr_next = (int'(gnt_q) == num_req_p - 1) ? '0 : gnt_q + 1'b1;

  // Round-robin pick: first valid requester at or after rr_q, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (req_v_i[idx]) begin
        pick_found = 1'b1;
        pick_idx   = gnt_w_lp'(idx);
      end
    end
  end

  // Grant FSM next state and consume strobes.
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    rr_d            = rr_q;
    req_ready_and_o = '0;
    case (state_q)
      e_idle: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          state_d = req_fence_i[pick_idx] ? e_fence : e_send;
        end
      end
      e_send: begin
        if (cmd_hs) begin
          req_ready_and_o[gnt_q] = 1'b1;
          rr_d                   = rr_next;
          state_d                = e_idle;
        end
      end
      e_fence: begin
        if (fence_done) begin
          req_ready_and_o[gnt_q] = 1'b1;
          rr_d                   = rr_next;
          state_d                = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // Outstanding-write counter; a completion with nothing outstanding is flagged.
  always_comb begin
    count_d = count_q;
    error_d = error_q;
    if (wr_hs & ~wr_done_i) begin
      count_d = count_q + 1'b1;
    end else if (~wr_hs & wr_done_i) begin
      if (count_q == '0) error_d = 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q <= e_idle;
      gnt_q   <= '0;
      rr_q    <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

endmodule
